// File: rtl/game_round_ctrl_if.sv
// Handshake bundle between the round controller, the keypad/level-select inputs
// and the display/score consumers.
interface game_round_ctrl_if;
   logic       level_sel;
   logic [1:0] level;
   logic       ans_valid;
   logic [3:0] ans_data;
   logic       target_valid;
   logic [3:0] target;
   logic [3:0] round_idx;
   logic [3:0] score;
   logic       busy;
   logic       done;
   logic       timeout_pulse;

   modport master (
      output level_sel, level, ans_valid, ans_data,
      input  target_valid, target, round_idx, score, busy, done, timeout_pulse
   );

   modport slave (
      input  level_sel, level, ans_valid, ans_data,
      output target_valid, target, round_idx, score, busy, done, timeout_pulse
   );
endinterface

// File: rtl/game_round_ctrl.sv
// One game level: seeds from a free-running scrambled counter, presents ROUNDS
// pseudo-random targets, waits for an answer or timeout on each, keeps score.
module game_round_ctrl #(
   parameter int unsigned       WIDTH   = 20,
   parameter logic [WIDTH-1:0]  STEP    = 20'hC9A4F,
   parameter int unsigned       ROUNDS  = 8,
   parameter int unsigned       TIMEOUT = 50000
) (
   input  logic               clk,
   input  logic               rst_n,
   game_round_ctrl_if.slave   bus
);

   localparam int unsigned TW   = $clog2(TIMEOUT + 1);
   localparam logic [3:0]  LAST = 4'(ROUNDS - 1);

   typedef enum logic [2:0] {IDLE, SEED, SHOW, WAIT, CHECK, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] r;
   logic [TW-1:0]    timer;
   logic             level_sel_q;
   logic [1:0]       lvl_q;
   logic [3:0]       target_q;
   logic [3:0]       round_q;
   logic [3:0]       score_q;
   logic [3:0]       ans_q;
   logic             answered_q;
   logic             level_edge;

   // xorshift-style mix; zero is a fixed point, so it is replaced by 1
   function automatic logic [WIDTH-1:0] scramble(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] y;
      y = x ^ (x << 7) ^ (x >> 5);
      return (y == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : y;
   endfunction

   assign level_edge = bus.level_sel & ~level_sel_q;

   // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE, DONE: if (level_edge) state_nx = SEED;
         SEED:       state_nx = SHOW;
         SHOW:       state_nx = WAIT;
         WAIT:       if (bus.ans_valid || timer == '0) state_nx = CHECK;
         CHECK:      state_nx = (round_q == LAST) ? DONE : SHOW;
         default:    state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.target_valid  = (state == WAIT);
      bus.busy          = state inside {SEED, SHOW, WAIT, CHECK};
      bus.done          = (state == DONE);
      bus.timeout_pulse = (state == CHECK) && !answered_q;
      bus.target        = target_q;
      bus.round_idx     = round_q;
      bus.score         = score_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         r           <= '0;
         timer       <= '0;
         level_sel_q <= 1'b0;
         lvl_q       <= '0;
         target_q    <= '0;
         round_q     <= '0;
         score_q     <= '0;
         ans_q       <= '0;
         answered_q  <= 1'b0;
      end else begin
         cnt         <= cnt + STEP;
         level_sel_q <= bus.level_sel;
         case (state)
            IDLE, DONE: if (level_edge) begin
               lvl_q   <= bus.level;
               r       <= scramble(cnt);
               score_q <= '0;
               round_q <= '0;
            end
            SHOW: begin
               unique case (lvl_q)
                  2'd0:    target_q <= {2'b00, r[1:0]};
                  2'd1:    target_q <= {1'b0, r[2:0]};
                  default: target_q <= r[3:0];
               endcase
               timer <= TW'((TIMEOUT >> lvl_q) - 1);
            end
            WAIT: begin
               // an answer on the last window cycle beats the timeout
               if (bus.ans_valid) begin
                  ans_q      <= bus.ans_data;
                  answered_q <= 1'b1;
               end else if (timer == '0) begin
                  answered_q <= 1'b0;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            CHECK: begin
               if (answered_q && ans_q == target_q && score_q != 4'hF)
                  score_q <= score_q + 4'd1;
               r <= scramble(r);
               if (round_q != LAST) round_q <= round_q + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomised and directed bench for game_round_ctrl against an in-bench
// behavioural model of the level/round/score rules.
module tb_game_round_ctrl;

   localparam int          WIDTH   = 20;
   localparam logic [19:0] STEP    = 20'hC9A4F;
   localparam int          ROUNDS  = 8;
   localparam int          TIMEOUT = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_miss = 0;

   game_round_ctrl_if bus();

   game_round_ctrl #(
      .WIDTH(WIDTH), .STEP(STEP), .ROUNDS(ROUNDS), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum int {M_IDLE, M_SEED, M_SHOW, M_WAIT, M_CHECK, M_DONE} mstage_t;

   mstage_t     m_st;
   logic [19:0] m_cnt, m_r;
   logic        m_lsq;
   logic [1:0]  m_lvl;
   int          m_score, m_round, m_age;
   logic [3:0]  m_target, m_ans;
   bit          m_answered;

   function automatic logic [19:0] scr(input logic [19:0] x);
      logic [19:0] y;
      y = x ^ (x << 7) ^ (x >> 5);
      return (y == 0) ? 20'd1 : y;
   endfunction

   function automatic int tbits(input logic [1:0] l);
      return (l == 0) ? 2 : (l == 1) ? 3 : 4;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st <= M_IDLE; m_cnt <= 0; m_r <= 0; m_lsq <= 0; m_lvl <= 0;
         m_score <= 0; m_round <= 0; m_age <= 0; m_target <= 0; m_ans <= 0;
         m_answered <= 0;
      end else begin
         m_lsq <= bus.level_sel;
         m_cnt <= m_cnt + STEP;
         case (m_st)
            M_IDLE, M_DONE: if (bus.level_sel && !m_lsq) begin
               m_st <= M_SEED; m_lvl <= bus.level; m_r <= scr(m_cnt);
               m_score <= 0; m_round <= 0;
            end
            M_SEED: m_st <= M_SHOW;
            M_SHOW: begin
               m_target <= 4'(m_r % (20'd1 << tbits(m_lvl)));
               m_age <= 0;
               m_st <= M_WAIT;
            end
            M_WAIT: begin
               if (bus.ans_valid) begin
                  m_answered <= 1; m_ans <= bus.ans_data; m_st <= M_CHECK;
               end else if (m_age == (TIMEOUT >> m_lvl) - 1) begin
                  m_answered <= 0; m_st <= M_CHECK;
               end else m_age <= m_age + 1;
            end
            M_CHECK: begin
               if (m_answered && m_ans == m_target)
                  m_score <= (m_score >= 15) ? 15 : m_score + 1;
               m_r <= scr(m_r);
               if (m_round == ROUNDS - 1) m_st <= M_DONE;
               else begin m_round <= m_round + 1; m_st <= M_SHOW; end
            end
            default: ;
         endcase
      end
   end

   // compare every cycle, away from the active edge
   always @(negedge clk) begin
      check("target_valid", bus.target_valid, m_st == M_WAIT);
      check("busy", bus.busy, m_st inside {M_SEED, M_SHOW, M_WAIT, M_CHECK});
      check("done", bus.done, m_st == M_DONE);
      check("timeout_pulse", bus.timeout_pulse, m_st == M_CHECK && !m_answered);
      check("target", bus.target, m_target);
      check("round_idx", bus.round_idx, m_round);
      check("score", bus.score, m_score);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [3:0] seen_t[$];

   task automatic answer(input logic [3:0] v);
      bus.ans_valid = 1'b1;
      bus.ans_data  = v;
   endtask

   task automatic start_level(input logic [1:0] lvl);
      bus.level_sel = 1'b1;
      bus.level     = lvl;
      @(negedge clk);
      bus.level_sel = 1'b0;
      check("start_score_clear", bus.score, 0);
      check("start_round_clear", bus.round_idx, 0);
      check("start_busy", bus.busy, 1);
      check("start_done_clear", bus.done, 0);
   endtask

   // mode 0 answer after delay, 1 answer F, 2 silent, 3 answer at timer==0,
   // 4 like 0 plus level_sel edge in WAIT, 5 wrong answer + stray strobes
   task automatic play(input logic [1:0] lvl, input int mode, input int delay);
      int   n_to = 0;
      int   n15  = 0;
      int   rise = 0;
      int   win;
      int   exp_score;
      logic tv_prev = 1'b0;
      win = TIMEOUT >> lvl;
      for (int c = 0; c < 4000 && m_st != M_DONE; c++) begin
         bus.ans_valid = 1'b0;
         if (bus.target_valid && !tv_prev) begin
            rise = cyc;
            seen_t.push_back(bus.target);
            if (m_target == 4'hF) n15++;
         end
         if (bus.timeout_pulse) begin
            n_to++;
            if (mode == 2) check("timeout_gap", cyc - rise, win);
         end
         tv_prev = bus.target_valid;
         if (m_st == M_WAIT) begin
            case (mode)
               0: if (m_age == delay - 1) answer(m_target);
               1: if (m_age == 0) answer(4'hF);
               3: if (m_age == win - 1) answer(m_target);
               4: begin
                  if (m_age == 1) begin bus.level_sel = 1'b1; bus.level = 2'($urandom); end
                  if (m_age == 2) bus.level_sel = 1'b0;
                  if (m_age == delay - 1) answer(m_target);
               end
               5: if (m_age == 0) answer(~m_target);
               default: ;
            endcase
         end
         if (mode == 5 && m_st inside {M_SEED, M_SHOW, M_CHECK}) answer(m_target);
         @(negedge clk);
      end
      bus.ans_valid = 1'b0;
      bus.level_sel = 1'b0;
      exp_score = (mode == 0 || mode == 3 || mode == 4) ? ROUNDS : (mode == 1) ? n15 : 0;
      check("level_done", bus.done, 1);
      check("level_busy_low", bus.busy, 0);
      check("final_round_idx", bus.round_idx, ROUNDS - 1);
      check("final_score", bus.score, exp_score);
      if (mode == 2) check("timeout_count", n_to, ROUNDS);
      if (mode == 3) check("no_timeout_on_tie", n_to, 0);
   endtask

   initial begin
      bus.level_sel = 1'b0; bus.level = '0; bus.ans_valid = 1'b0; bus.ans_data = '0;

      // reset with random inputs
      for (int i = 0; i < 6; i++) begin
         bus.level_sel = 1'($urandom); bus.level = 2'($urandom);
         bus.ans_valid = 1'($urandom); bus.ans_data = 4'($urandom);
         @(negedge clk);
         check("rst_busy", bus.busy, 0);
         check("rst_score", bus.score, 0);
         check("rst_tv", bus.target_valid, 0);
      end
      bus.level_sel = 1'b0; bus.ans_valid = 1'b0;
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);

      // seed forced to 1: level_sel high across reset release
      rst_n = 1'b0;
      bus.level_sel = 1'b1; bus.level = 2'd2;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.level_sel = 1'b0;
      check("seed_tv_n0", bus.target_valid, 0);
      @(negedge clk);
      check("seed_tv_n1", bus.target_valid, 0);
      @(negedge clk);
      check("seed_tv_n2", bus.target_valid, 1);
      seen_t.delete();
      play(2'd2, 0, 3);
      if (seen_t.size() >= 3) begin
         check("seed_target0", seen_t[0], 1);
         check("seed_target1", seen_t[1], 1);
         check("seed_target2", seen_t[2], 5);
      end else check("seed_target_count", seen_t.size(), 3);
      check("seed_score", bus.score, 8);

      start_level(2'd2); play(2'd2, 1, 0);
      start_level(2'd1); play(2'd1, 2, 0);
      start_level(2'd3); play(2'd3, 3, 0);
      start_level(2'd0); play(2'd0, 4, 5);
      start_level(2'd1); play(2'd1, 5, 0);

      // asynchronous reset in the middle of a WAIT
      start_level(2'd0);
      for (int c = 0; c < 400; c++) begin
         bus.ans_valid = 1'b0;
         if (m_st == M_WAIT && m_round == 2) break;
         if (m_st == M_WAIT) answer(m_target);
         @(negedge clk);
      end
      bus.ans_valid = 1'b0;
      check("pre_reset_score", bus.score, 2);
      check("pre_reset_tv", bus.target_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_tv", bus.target_valid, 0);
      check("async_rst_busy", bus.busy, 0);
      check("async_rst_score", bus.score, 0);
      check("async_rst_round", bus.round_idx, 0);
      check("async_rst_target", bus.target, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // random phase
      for (int i = 0; i < 6000; i++) begin
         bus.level_sel = ($urandom_range(0, 7) == 0);
         bus.level     = 2'($urandom);
         bus.ans_valid = ($urandom_range(0, 3) == 0);
         bus.ans_data  = 4'($urandom);
         if (m_st == M_WAIT && $urandom_range(0, 2) == 0) bus.ans_data = m_target;
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
